// File: rtl/kinase_valve_sequencer_if.sv
// rtl/kinase_valve_sequencer_if.sv - command handshake bundle for the valve sequencer
interface kinase_valve_sequencer_if #(
   parameter int ARG_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [ARG_W-1:0] cmd_arg;
   logic             abort;

   // Host side: issues commands and aborts
   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_arg,
      output abort,
      input  cmd_ready
   );

   // Sequencer side: consumes commands
   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_arg,
      input  abort,
      output cmd_ready
   );
endinterface

// File: rtl/kinase_valve_sequencer.sv
// rtl/kinase_valve_sequencer.sv - command-driven solenoid sequencer for ctrl, pump and flush lines
module kinase_valve_sequencer #(
   parameter int STEP_TICKS  = 16,
   parameter int FLUSH_TICKS = 64,
   parameter int ARG_W       = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   kinase_valve_sequencer_if.slave     cmd,
   output logic [12:0]                 ctrl_a,
   output logic [3:0]                  ctrl_s,
   output logic [2:0]                  pump_a,
   output logic [1:0]                  pump_b,
   output logic [12:0]                 flush_ctrl_a,
   output logic [3:0]                  flush_ctrl_s,
   output logic [2:0]                  flush_pump_a,
   output logic [1:0]                  flush_pump_b,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

   localparam int MAX_TICKS = (STEP_TICKS > FLUSH_TICKS) ? STEP_TICKS : FLUSH_TICKS;
   localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam logic [TICK_W-1:0] STEP_LAST  = TICK_W'(STEP_TICKS - 1);
   localparam logic [TICK_W-1:0] FLUSH_LAST = TICK_W'(FLUSH_TICKS - 1);

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_SET_A = 3'd1;
   localparam logic [2:0] OP_SET_S = 3'd2;
   localparam logic [2:0] OP_PUMPA = 3'd3;
   localparam logic [2:0] OP_PUMPB = 3'd4;
   localparam logic [2:0] OP_WAIT  = 3'd5;
   localparam logic [2:0] OP_FLUSH = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_PUMP,
      S_WAIT,
      S_FLUSH
   } state_t;

   state_t            state_q, state_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [2:0]        phase_q, phase_d;
   logic [ARG_W-1:0]  cyc_q, cyc_d;
   logic              sel_b_q, sel_b_d;

   logic [12:0] ctrl_a_d, flush_ctrl_a_d;
   logic [3:0]  ctrl_s_d, flush_ctrl_s_d;
   logic [2:0]  pump_a_d, flush_pump_a_d;
   logic [1:0]  pump_b_d, flush_pump_b_d;
   logic        done_d, err_d;
   logic        accept;
   logic [2:0]  last_phase;
   logic [2:0]  phase_nx;

   // Six-phase peristaltic pattern for the 3-valve pump
   function automatic logic [2:0] pattern_a(input logic [2:0] ph);
      case (ph)
         3'd0:    return 3'b100;
         3'd1:    return 3'b110;
         3'd2:    return 3'b010;
         3'd3:    return 3'b011;
         3'd4:    return 3'b001;
         default: return 3'b101;
      endcase
   endfunction

   // Two-phase alternation for the 2-valve pump
   function automatic logic [1:0] pattern_b(input logic [2:0] ph);
      return ph[0] ? 2'b01 : 2'b10;
   endfunction

   assign cmd.cmd_ready = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign accept        = cmd.cmd_valid && (state_q == S_IDLE);
   assign last_phase    = sel_b_q ? 3'd1 : 3'd5;
   assign phase_nx      = (phase_q == last_phase) ? 3'd0 : phase_q + 3'd1;

   // Register every piece of state and every output; reset drops all drives at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tick_q       <= '0;
         phase_q      <= '0;
         cyc_q        <= '0;
         sel_b_q      <= 1'b0;
         ctrl_a       <= '0;
         ctrl_s       <= '0;
         pump_a       <= '0;
         pump_b       <= '0;
         flush_ctrl_a <= '0;
         flush_ctrl_s <= '0;
         flush_pump_a <= '0;
         flush_pump_b <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         phase_q      <= phase_d;
         cyc_q        <= cyc_d;
         sel_b_q      <= sel_b_d;
         ctrl_a       <= ctrl_a_d;
         ctrl_s       <= ctrl_s_d;
         pump_a       <= pump_a_d;
         pump_b       <= pump_b_d;
         flush_ctrl_a <= flush_ctrl_a_d;
         flush_ctrl_s <= flush_ctrl_s_d;
         flush_pump_a <= flush_pump_a_d;
         flush_pump_b <= flush_pump_b_d;
         done         <= done_d;
         err          <= err_d;
      end
   end

   // Next-state and next-output decode; done marks the single completion cycle,
   // after which the sequencer drops back to IDLE on the following edge
   always_comb begin
      state_d        = state_q;
      tick_d         = tick_q;
      phase_d        = phase_q;
      cyc_d          = cyc_q;
      sel_b_d        = sel_b_q;
      ctrl_a_d       = ctrl_a;
      ctrl_s_d       = ctrl_s;
      pump_a_d       = pump_a;
      pump_b_d       = pump_b;
      flush_ctrl_a_d = flush_ctrl_a;
      flush_ctrl_s_d = flush_ctrl_s;
      flush_pump_a_d = flush_pump_a;
      flush_pump_b_d = flush_pump_b;
      done_d         = 1'b0;
      err_d          = err;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (cmd.cmd_op)
                  OP_NOP: begin
                     state_d = S_EXEC;
                     done_d  = 1'b1;
                  end
                  OP_SET_A: begin
                     ctrl_a_d = cmd.cmd_arg[12:0];
                     state_d  = S_EXEC;
                     done_d   = 1'b1;
                  end
                  OP_SET_S: begin
                     ctrl_s_d = cmd.cmd_arg[3:0];
                     state_d  = S_EXEC;
                     done_d   = 1'b1;
                  end
                  OP_PUMPA, OP_PUMPB: begin
                     state_d = S_PUMP;
                     sel_b_d = (cmd.cmd_op == OP_PUMPB);
                     tick_d  = '0;
                     phase_d = '0;
                     cyc_d   = cmd.cmd_arg;
                     // A zero-cycle pump completes without touching the valves
                     if (cmd.cmd_arg == '0) begin
                        done_d = 1'b1;
                     end else if (cmd.cmd_op == OP_PUMPB) begin
                        pump_b_d = pattern_b(3'd0);
                     end else begin
                        pump_a_d = pattern_a(3'd0);
                     end
                  end
                  OP_WAIT: begin
                     state_d = S_WAIT;
                     cyc_d   = cmd.cmd_arg;
                     if (cmd.cmd_arg == '0) begin
                        done_d = 1'b1;
                     end
                  end
                  OP_FLUSH: begin
                     // ctrl/pump drop on the same edge that raises flush
                     state_d        = S_FLUSH;
                     tick_d         = '0;
                     ctrl_a_d       = '0;
                     ctrl_s_d       = '0;
                     pump_a_d       = '0;
                     pump_b_d       = '0;
                     flush_ctrl_a_d = '1;
                     flush_ctrl_s_d = '1;
                     flush_pump_a_d = '1;
                     flush_pump_b_d = '1;
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_EXEC;
                     done_d  = 1'b1;
                  end
               endcase
            end
         end

         S_EXEC: begin
            state_d = S_IDLE;
         end

         S_PUMP, S_WAIT, S_FLUSH: begin
            if (done) begin
               state_d = S_IDLE;
            end else if (cmd.abort) begin
               state_d        = S_IDLE;
               pump_a_d       = '0;
               pump_b_d       = '0;
               flush_ctrl_a_d = '0;
               flush_ctrl_s_d = '0;
               flush_pump_a_d = '0;
               flush_pump_b_d = '0;
            end else if (state_q == S_PUMP) begin
               if (tick_q == STEP_LAST) begin
                  tick_d = '0;
                  if ((phase_q == last_phase) && (cyc_q == ARG_W'(1))) begin
                     pump_a_d = '0;
                     pump_b_d = '0;
                     done_d   = 1'b1;
                  end else begin
                     if (phase_q == last_phase) begin
                        cyc_d = cyc_q - ARG_W'(1);
                     end
                     phase_d = phase_nx;
                     if (sel_b_q) begin
                        pump_b_d = pattern_b(phase_nx);
                     end else begin
                        pump_a_d = pattern_a(phase_nx);
                     end
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end else if (state_q == S_WAIT) begin
               if (cyc_q == ARG_W'(1)) begin
                  done_d = 1'b1;
               end else begin
                  cyc_d = cyc_q - ARG_W'(1);
               end
            end else begin
               if (tick_q == FLUSH_LAST) begin
                  flush_ctrl_a_d = '0;
                  flush_ctrl_s_d = '0;
                  flush_pump_a_d = '0;
                  flush_pump_b_d = '0;
                  done_d         = 1'b1;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
